// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
// Hits return one cycle after the request. Misses refill the whole line word
// by word over a req/rdy memory port, then return the requested word.
// icache_flush invalidates every line (fence.i).
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] icache_addr,
    input  logic        icache_req,
    output logic [31:0] icache_data,
    output logic        icache_rdy,
    input  logic        icache_flush,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic [31:0]      rdata_q, rdata_d;

    // Tag and data storage carry no reset; the valid bits qualify them.
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*WORDS];

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic             refill_wr;
    logic             refill_last;

    // Bits [1:0] select a byte within the word and play no part in lookup.
    logic unused_addr_lo;
    assign unused_addr_lo = ^icache_addr[1:0];

    assign req_off = icache_addr[2 +: OFF_W];
    assign req_idx = icache_addr[2+OFF_W +: IDX_W];
    assign req_tag = icache_addr[31 -: TAG_W];
    assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // mem_rdy only counts while a refill is actually requesting.
    assign refill_wr   = (state_q == S_REFILL) && mem_rdy;
    assign refill_last = refill_wr && (cnt_q == OFF_W'(WORDS-1));

    assign icache_rdy  = (state_q == S_RESP);
    assign icache_data = rdata_q;
    assign mem_req     = (state_q == S_REFILL);
    assign mem_addr    = mem_req ? {tag_q, idx_q, cnt_q, 2'b00} : 32'h0;

    // Next-state logic for the controller, valid bits and response word.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        rdata_d      = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (icache_flush) begin
                    // A request alongside a flush waits a cycle and then misses.
                    valid_d = '0;
                end else if (icache_req) begin
                    if (hit) begin
                        rdata_d = data_mem[{req_idx, req_off}];
                        state_d = S_RESP;
                    end else begin
                        tag_d   = req_tag;
                        idx_d   = req_idx;
                        off_d   = req_off;
                        cnt_d   = '0;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                if (icache_flush) flush_pend_d = 1'b1;
                if (mem_rdy) begin
                    if (cnt_q == off_q) rdata_d = mem_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (refill_last) begin
                        valid_d[idx_q] = 1'b1;
                        // A flush seen during the refill also kills the new line.
                        if (flush_pend_q || icache_flush) valid_d = '0;
                        flush_pend_d = 1'b0;
                        state_d      = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (icache_flush) valid_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state; reset abandons any refill in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            tag_q        <= '0;
            idx_q        <= '0;
            off_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            rdata_q      <= rdata_d;
        end
    end

    // Line fill: each returned word lands in the data array, tag on the last.
    always_ff @(posedge clock) begin
        if (refill_wr)   data_mem[{idx_q, cnt_q}] <= mem_rdata;
        if (refill_last) tag_mem[idx_q] <= tag_q;
    end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed, table-driven checks of icache_dm (LINES=16, WORDS=4)
// against a simple memory responder that answers each word two cycles after
// the request.
module tb_icache_dm;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] icache_addr = 32'h0;
    logic        icache_req = 1'b0;
    logic [31:0] icache_data;
    logic        icache_rdy;
    logic        icache_flush = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rdy = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    icache_dm #(.LINES(16), .WORDS(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .icache_addr  (icache_addr),
        .icache_req   (icache_req),
        .icache_data  (icache_data),
        .icache_rdy   (icache_rdy),
        .icache_flush (icache_flush),
        .mem_addr     (mem_addr),
        .mem_req      (mem_req),
        .mem_rdata    (mem_rdata),
        .mem_rdy      (mem_rdy)
    );

    always #5 clock = ~clock;

    // Memory contents: word at 0x100 is 0xA0, incrementing per word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h100) >> 2);
    endfunction

    // Responder: inputs change on the falling edge, away from DUT sampling.
    int          wcnt = 0;
    int          rdy_cnt = 0;
    logic [31:0] addr_log [256];
    always @(negedge clock) begin
        if (mem_rdy) begin
            mem_rdy = 1'b0;
            wcnt    = 0;
        end else if (mem_req) begin
            wcnt = wcnt + 1;
            if (wcnt == 2) begin
                mem_rdy   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                addr_log[rdy_cnt[7:0]] = mem_addr;
                rdy_cnt   = rdy_cnt + 1;
                wcnt      = 0;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One fetch: miss latency is 12 with the 3-cycle-per-word responder.
    task automatic fetch(input logic [31:0] a, input logic [31:0] ed, input bit em, input string nm);
        bit got;
        bit saw_mem;
        int cyc;
        got = 1'b0;
        saw_mem = 1'b0;
        cyc = 0;
        @(negedge clock);
        icache_addr = a;
        icache_req  = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (mem_req) saw_mem = 1'b1;
            if (icache_rdy) begin
                got = 1'b1;
                cyc = i;
                break;
            end
        end
        icache_req = 1'b0;
        if (!got) begin
            n_chk  = n_chk + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s timeout: no icache_rdy within 40 cycles", nm);
        end else begin
            chk({nm, " data"}, icache_data, ed);
            chk({nm, " miss"}, {31'h0, saw_mem}, {31'h0, em});
            chk({nm, " latency"}, cyc, em ? 32'd12 : 32'd1);
            @(posedge clock);
            #1;
            chk({nm, " rdy pulse"}, {31'h0, icache_rdy}, 32'h0);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
        bit          exp_miss;
        string       name;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int base;
        bit hit2;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit reached;
        vecs[0] = '{32'h108, 32'hA2,  1'b1, "cold miss 0x108"};
        vecs[1] = '{32'h10C, 32'hA3,  1'b0, "hit 0x10C"};
        vecs[2] = '{32'h100, 32'hA0,  1'b0, "hit 0x100"};
        vecs[3] = '{32'h500, 32'h1A0, 1'b1, "conflict 0x500"};
        vecs[4] = '{32'h100, 32'hA0,  1'b1, "evicted 0x100"};
        vecs[5] = '{32'h104, 32'hA1,  1'b0, "hit 0x104"};

        // Reset state
        repeat (3) @(negedge clock);
        chk("reset rdy", {31'h0, icache_rdy}, 32'h0);
        chk("reset data", icache_data, 32'h0);
        chk("reset mem_req", {31'h0, mem_req}, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        reset = 1'b1;

        // Table-driven fetches
        for (int v = 0; v < 6; v++) begin
            base = rdy_cnt;
            fetch(vecs[v].addr, vecs[v].exp_data, vecs[v].exp_miss, vecs[v].name);
            if (v == 0) begin
                for (int w = 0; w < 4; w++)
                    chk("cold miss mem_addr", addr_log[base + w], 32'h100 + 32'(w * 4));
            end
        end

        // Flush in IDLE together with a request: no response, then a miss
        @(negedge clock);
        icache_flush = 1'b1;
        icache_addr  = 32'h104;
        icache_req   = 1'b1;
        @(posedge clock);
        #1;
        icache_flush = 1'b0;
        chk("flush idle rdy", {31'h0, icache_rdy}, 32'h0);
        chk("flush idle mem_req", {31'h0, mem_req}, 32'h0);
        fetch(32'h104, 32'hA1, 1'b1, "after flush 0x104");

        // Flush during refill: data still returned, line left invalid
        fork
            fetch(32'h508, 32'h1A2, 1'b1, "flush in refill 0x508");
            begin
                repeat (4) @(negedge clock);
                icache_flush = 1'b1;
                @(negedge clock);
                icache_flush = 1'b0;
            end
        join
        fetch(32'h508, 32'h1A2, 1'b1, "refetch 0x508");

        // Reset right after the second word of a refill
        base = rdy_cnt;
        reached = 1'b0;
        @(negedge clock);
        icache_addr = 32'h100;
        icache_req  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (rdy_cnt == base + 2) begin
                reached = 1'b1;
                break;
            end
        end
        chk("mid-refill reached 2nd word", {31'h0, reached}, 32'h1);
        reset = 1'b0;
        #1;
        chk("mid-refill reset mem_req", {31'h0, mem_req}, 32'h0);
        chk("mid-refill reset rdy", {31'h0, icache_rdy}, 32'h0);
        chk("mid-refill reset data", icache_data, 32'h0);
        chk("mid-refill reset mem_addr", mem_addr, 32'h0);
        icache_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        base = rdy_cnt;
        fetch(32'h100, 32'hA0, 1'b1, "refill after reset 0x100");
        for (int w = 0; w < 4; w++)
            chk("refill after reset mem_addr", addr_log[base + w], 32'h100 + 32'(w * 4));

        // Request held through RESP: one response every other cycle
        @(negedge clock);
        icache_addr = 32'h100;
        icache_req  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            chk("held req rdy", {31'h0, icache_rdy}, (i % 2 == 0) ? 32'h1 : 32'h0);
            if (i % 2 == 0) chk("held req data", icache_data, 32'hA0);
            chk("held req mem_req", {31'h0, mem_req}, 32'h0);
        end
        icache_req = 1'b0;

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
